// File: rtl/regfile_pkg.sv
// Shared types and helpers for the paired register file.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
//
// Contents: clog2 helper, default-width register/pair types, and the
// offsets of the high and low registers within a pair.
package regfile_pkg;

    localparam int DEF_WIDTH = 8;

    typedef logic [DEF_WIDTH-1:0]   reg_t;
    typedef logic [2*DEF_WIDTH-1:0] pair_t;

    // Pair p occupies reg[2p] (high half) and reg[2p+1] (low half).
    localparam logic PAIR_HI_OFS = 1'b0;
    localparam logic PAIR_LO_OFS = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/register_file_paired_incdec.sv
// Combinational +/-1 on a register pair, with wrap-around detection.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; result is always valid for the current input.
//
// Ports: pair_in (2*WIDTH) value to adjust, dec (0 = +1, 1 = -1),
//        pair_out (2*WIDTH) adjusted value, wrap (1 when the step crosses
//        all-ones <-> zero).
module pair_incdec #(
    parameter int WIDTH = 8
) (
    input  logic [2*WIDTH-1:0] pair_in,
    input  logic               dec,
    output logic [2*WIDTH-1:0] pair_out,
    output logic               wrap
);

    localparam int PWID = 2 * WIDTH;
    localparam logic [PWID-1:0] ONE = PWID'(1);

    // The carry/borrow from the low half into the high half falls out of the
    // full-width add, so both halves are handled as one number.
    assign pair_out = dec ? (pair_in - ONE) : (pair_in + ONE);
    assign wrap     = dec ? (pair_in == '0) : (&pair_in);

endmodule

// File: rtl/register_file_paired.sv
// General-purpose register file with single/pair access and a pointer-pair inc/dec engine.
// Latency: writes and inc/dec land in stored state after 1 edge; reads are combinational.
// Backpressure: none; every request is accepted each cycle, writes beat a colliding inc/dec.
//
// Ports: clk, reset (sync, active-high); write port wr_en/wr_pair/wr_addr/wr_data;
//        read ports rd_addr_a/rd_data_a, rd_addr_b/rd_data_b; pair read rp_sel/rp_data;
//        inc/dec port inc_en/dec_en/inc_sel with registered wrap pulse inc_wrap.
module register_file_paired
    import regfile_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int NUM_REGS = 8,
    parameter  bit BYPASS   = 1'b1,
    localparam int AW       = clog2(NUM_REGS),
    localparam int PW       = AW - 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic               wr_pair,
    input  logic [AW-1:0]      wr_addr,
    input  logic [2*WIDTH-1:0] wr_data,
    input  logic [AW-1:0]      rd_addr_a,
    output logic [WIDTH-1:0]   rd_data_a,
    input  logic [AW-1:0]      rd_addr_b,
    output logic [WIDTH-1:0]   rd_data_b,
    input  logic [PW-1:0]      rp_sel,
    output logic [2*WIDTH-1:0] rp_data,
    input  logic               inc_en,
    input  logic               dec_en,
    input  logic [PW-1:0]      inc_sel,
    output logic               inc_wrap
);

    logic [WIDTH-1:0]    regs    [NUM_REGS];
    logic [WIDTH-1:0]    wr_val  [NUM_REGS];
    logic [WIDTH-1:0]    nxt_val [NUM_REGS];
    logic [NUM_REGS-1:0] wr_hit;
    logic [NUM_REGS-1:0] inc_hit;

    logic [AW-1:0]       inc_hi_idx, inc_lo_idx;
    logic [AW-1:0]       rp_hi_idx, rp_lo_idx;
    logic [2*WIDTH-1:0]  inc_src, inc_res;
    logic                inc_req, inc_collide, inc_go, inc_wrap_raw;

    assign inc_hi_idx = {inc_sel, PAIR_HI_OFS};
    assign inc_lo_idx = {inc_sel, PAIR_LO_OFS};
    assign rp_hi_idx  = {rp_sel, PAIR_HI_OFS};
    assign rp_lo_idx  = {rp_sel, PAIR_LO_OFS};

    // inc and dec together cancel out. Any write landing on either half of the
    // selected pair kills the whole step so no half-applied carry can occur.
    assign inc_req     = inc_en ^ dec_en;
    assign inc_collide = wr_hit[inc_hi_idx] | wr_hit[inc_lo_idx];
    assign inc_go      = inc_req & ~inc_collide;
    assign inc_src     = {regs[inc_hi_idx], regs[inc_lo_idx]};

    pair_incdec #(
        .WIDTH (WIDTH)
    ) u_incdec (
        .pair_in  (inc_src),
        .dec      (dec_en),
        .pair_out (inc_res),
        .wrap     (inc_wrap_raw)
    );

    // Per-register write decode and next-value selection.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        localparam logic [AW-1:0] IDX   = AW'(i);
        localparam logic          IS_LO = (IDX[0] == PAIR_LO_OFS);

        assign wr_hit[i]  = wr_en & (wr_pair ? (wr_addr[AW-1:1] == IDX[AW-1:1])
                                             : (wr_addr == IDX));
        assign wr_val[i]  = (wr_pair && !IS_LO) ? wr_data[2*WIDTH-1:WIDTH]
                                                : wr_data[WIDTH-1:0];
        assign inc_hit[i] = inc_go & (inc_sel == IDX[AW-1:1]);
        assign nxt_val[i] = wr_hit[i]  ? wr_val[i] :
                            inc_hit[i] ? (IS_LO ? inc_res[WIDTH-1:0]
                                                : inc_res[2*WIDTH-1:WIDTH]) :
                                         regs[i];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            inc_wrap <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= nxt_val[i];
            end
            inc_wrap <= inc_go & inc_wrap_raw;
        end
    end

    // Forwarding covers only write data; inc/dec results show up from storage
    // on the following cycle.
    if (BYPASS) begin : g_bypass
        assign rd_data_a = wr_hit[rd_addr_a] ? wr_val[rd_addr_a] : regs[rd_addr_a];
        assign rd_data_b = wr_hit[rd_addr_b] ? wr_val[rd_addr_b] : regs[rd_addr_b];
        assign rp_data   = {wr_hit[rp_hi_idx] ? wr_val[rp_hi_idx] : regs[rp_hi_idx],
                            wr_hit[rp_lo_idx] ? wr_val[rp_lo_idx] : regs[rp_lo_idx]};
    end else begin : g_direct
        assign rd_data_a = regs[rd_addr_a];
        assign rd_data_b = regs[rd_addr_b];
        assign rp_data   = {regs[rp_hi_idx], regs[rp_lo_idx]};
    end

endmodule

// File: tb/tb_register_file_paired.sv
// Directed testbench for register_file_paired (BYPASS=1 instance plus a BYPASS=0 twin).
// Both instances share every input; outputs are checked against hand-computed values.
module tb_register_file_paired;
    import regfile_pkg::*;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic        wr_pair;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [2:0]  rd_addr_a;
    logic [2:0]  rd_addr_b;
    logic [1:0]  rp_sel;
    logic        inc_en;
    logic        dec_en;
    logic [1:0]  inc_sel;

    logic [7:0]  rd_data_a, rd_data_b;
    logic [15:0] rp_data;
    logic        inc_wrap;
    logic [7:0]  nb_rd_data_a, nb_rd_data_b;
    logic [15:0] nb_rp_data;
    logic        nb_inc_wrap;

    int n_tests;
    int n_fail;

    register_file_paired #(.WIDTH(8), .NUM_REGS(8), .BYPASS(1'b1)) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_pair(wr_pair), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
        .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
        .rp_sel(rp_sel), .rp_data(rp_data),
        .inc_en(inc_en), .dec_en(dec_en), .inc_sel(inc_sel), .inc_wrap(inc_wrap)
    );

    register_file_paired #(.WIDTH(8), .NUM_REGS(8), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_pair(wr_pair), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_data_a(nb_rd_data_a),
        .rd_addr_b(rd_addr_b), .rd_data_b(nb_rd_data_b),
        .rp_sel(rp_sel), .rp_data(nb_rp_data),
        .inc_en(inc_en), .dec_en(dec_en), .inc_sel(inc_sel), .inc_wrap(nb_inc_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Advance past one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en  = 1'b0;
        wr_pair = 1'b0;
        inc_en = 1'b0;
        dec_en = 1'b0;
    endtask

    task automatic pair_write(input logic [2:0] addr, input pair_t val);
        wr_en = 1'b1; wr_pair = 1'b1; wr_addr = addr; wr_data = val;
        tick();
        idle();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1;
        idle();
        wr_addr = '0; wr_data = '0;
        rd_addr_a = '0; rd_addr_b = '0; rp_sel = '0; inc_sel = '0;
        tick();
        reset = 1'b0;

        // 1. Fill with junk, then reset and read everything back as zero.
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_pair = 1'b0; wr_addr = 3'(i);
            wr_data = 16'($urandom_range(1, 255));
            tick();
        end
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i);
            #1;
            chk($sformatf("reset_reg%0d", i), {8'h00, rd_data_a}, 16'h0000);
        end
        chk("reset_wrap", {15'd0, inc_wrap}, 16'h0000);

        // 2. Pair write to pair 1 via odd address, with same-cycle bypass.
        wr_en = 1'b1; wr_pair = 1'b1; wr_addr = 3'd3; wr_data = 16'hBEEF;
        rp_sel = 2'd1; rd_addr_a = 3'd2;
        #1;
        chk("pairwr_byp_rd_a", {8'h00, rd_data_a}, 16'h00BE);
        chk("pairwr_byp_rp", rp_data, 16'hBEEF);
        chk("pairwr_nobyp_rp", nb_rp_data, 16'h0000);
        tick();
        idle();
        rd_addr_b = 3'd3;
        #1;
        chk("pairwr_rp", rp_data, 16'hBEEF);
        chk("pairwr_reg2", {8'h00, rd_data_a}, 16'h00BE);
        chk("pairwr_reg3", {8'h00, rd_data_b}, 16'h00EF);

        // 3. Increment with carry, increment wrap, decrement wrap on pair 2.
        pair_write(3'd4, 16'h12FF);
        inc_en = 1'b1; inc_sel = 2'd2; rp_sel = 2'd2;
        tick();
        idle();
        chk("inc_carry", rp_data, 16'h1300);
        chk("inc_carry_wrap", {15'd0, inc_wrap}, 16'h0000);
        pair_write(3'd4, 16'hFFFF);
        inc_en = 1'b1;
        tick();
        idle();
        chk("inc_ovf", rp_data, 16'h0000);
        chk("inc_ovf_wrap", {15'd0, inc_wrap}, 16'h0001);
        tick();
        chk("inc_ovf_wrap_drop", {15'd0, inc_wrap}, 16'h0000);
        pair_write(3'd4, 16'h0000);
        dec_en = 1'b1;
        tick();
        idle();
        chk("dec_udf", rp_data, 16'hFFFF);
        chk("dec_udf_wrap", {15'd0, inc_wrap}, 16'h0001);

        // 4. Single write into the low half of the inc pair drops the inc.
        pair_write(3'd4, 16'h00FF);
        wr_en = 1'b1; wr_pair = 1'b0; wr_addr = 3'd5; wr_data = 16'h00AA;
        inc_en = 1'b1; inc_sel = 2'd2;
        tick();
        idle();
        rd_addr_a = 3'd5; rd_addr_b = 3'd4;
        #1;
        chk("collide_reg5", {8'h00, rd_data_a}, 16'h00AA);
        chk("collide_reg4", {8'h00, rd_data_b}, 16'h0000);
        chk("collide_wrap", {15'd0, inc_wrap}, 16'h0000);

        // 5. inc+dec together hold the pair; an unrelated write still lands.
        pair_write(3'd0, 16'h1234);
        inc_en = 1'b1; dec_en = 1'b1; inc_sel = 2'd0;
        wr_en = 1'b1; wr_pair = 1'b0; wr_addr = 3'd7; wr_data = 16'h0055;
        tick();
        idle();
        rp_sel = 2'd0; rd_addr_a = 3'd7;
        #1;
        chk("incdec_hold", rp_data, 16'h1234);
        chk("incdec_wrap", {15'd0, inc_wrap}, 16'h0000);
        chk("incdec_reg7", {8'h00, rd_data_a}, 16'h0055);

        // Non-overlapping write and inc in the same cycle both apply.
        inc_en = 1'b1; inc_sel = 2'd1;
        wr_en = 1'b1; wr_pair = 1'b0; wr_addr = 3'd6; wr_data = 16'h0066;
        tick();
        idle();
        rp_sel = 2'd1; rd_addr_a = 3'd6;
        #1;
        chk("parallel_inc", rp_data, 16'hBEF0);
        chk("parallel_reg6", {8'h00, rd_data_a}, 16'h0066);

        // 6. No forwarding in the BYPASS=0 build (reg1 currently 0x34).
        wr_en = 1'b1; wr_pair = 1'b0; wr_addr = 3'd1; wr_data = 16'h007E;
        rd_addr_b = 3'd1;
        #1;
        chk("nobyp_same_cycle", {8'h00, nb_rd_data_b}, 16'h0034);
        chk("byp_same_cycle", {8'h00, rd_data_b}, 16'h007E);
        tick();
        idle();
        #1;
        chk("nobyp_next_cycle", {8'h00, nb_rd_data_b}, 16'h007E);

        // 7. Reset overrides a wrapping increment of pair 3.
        pair_write(3'd6, 16'hFFFF);
        inc_en = 1'b1; inc_sel = 2'd3; reset = 1'b1;
        tick();
        idle();
        reset = 1'b0;
        rp_sel = 2'd3;
        #1;
        chk("rst_inc_pair3", rp_data, 16'h0000);
        chk("rst_inc_wrap", {15'd0, inc_wrap}, 16'h0000);
        rp_sel = 2'd1;
        #1;
        chk("rst_inc_pair1", rp_data, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
